// File: rtl/shifter_pkg.sv
// Operation encodings shared by the pipelined shifter and its mux levels.
package shifter_pkg;
   localparam logic [1:0] OP_ROL = 2'b00;
   localparam logic [1:0] OP_SLL = 2'b01;
   localparam logic [1:0] OP_ROR = 2'b10;
   localparam logic [1:0] OP_SRA = 2'b11;

   function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
      return (a + b - 1) / b;
   endfunction
endpackage

// File: rtl/shift_level.sv
// One barrel-shifter mux level: shift or rotate by a fixed DIST when en_i is set.
module shift_level
   import shifter_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIST  = 1
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic             en_i,
   input  logic [1:0]       op_i,
   output logic [WIDTH-1:0] data_o
);

   always_comb begin
      data_o = data_i;
      if (en_i) begin
         case (op_i)
            OP_ROL:  data_o = {data_i[WIDTH-DIST-1:0], data_i[WIDTH-1:WIDTH-DIST]};
            OP_SLL:  data_o = {data_i[WIDTH-DIST-1:0], {DIST{1'b0}}};
            OP_ROR:  data_o = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
            default: data_o = {{DIST{data_i[WIDTH-1]}}, data_i[WIDTH-1:DIST]};
         endcase
      end
   end

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter/rotator: CNT_W mux levels grouped REG_EVERY per stage,
// with an elastic valid/ready pipeline so backpressure stalls without loss.
module pipe_shifter
   import shifter_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int CNT_W     = $clog2(WIDTH),
   parameter int REG_EVERY = 1,
   parameter int TAG_W     = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [CNT_W-1:0] in_cnt,
   input  logic [1:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAG_W-1:0] out_tag
);

   localparam int NSTG = int'(ceil_div(CNT_W, REG_EVERY));

   logic [NSTG-1:0] v;
   logic [NSTG-1:0] rdy;
   logic            nxt;

   // A stage can take new work if it is empty or its content moves on this cycle;
   // walking back from the output lets bubbles collapse.
   always_comb begin
      rdy = '0;
      nxt = out_ready;
      for (int s = NSTG - 1; s >= 0; s--) begin
         rdy[s] = ~v[s] | nxt;
         nxt    = rdy[s];
      end
   end

   for (genvar s = 0; s < NSTG; s++) begin : stg_g
      localparam int BASE = s * REG_EVERY;
      localparam int NL   = (CNT_W - BASE < REG_EVERY) ? (CNT_W - BASE) : REG_EVERY;

      logic             up_v;
      logic [WIDTH-1:0] up_data;
      logic [CNT_W-1:0] up_cnt;
      logic [1:0]       up_op;
      logic [TAG_W-1:0] up_tag;
      logic [WIDTH-1:0] data_d;

      logic             v_q;
      logic [WIDTH-1:0] data_q;
      logic [TAG_W-1:0] tag_q;

      if (s == 0) begin : src_in_g
         assign up_v    = in_valid;
         assign up_data = in_data;
         assign up_cnt  = in_cnt;
         assign up_op   = in_op;
         assign up_tag  = in_tag;
      end else begin : src_stg_g
         assign up_v    = stg_g[s-1].v_q;
         assign up_data = stg_g[s-1].data_q;
         assign up_cnt  = stg_g[s-1].cnt_g.cnt_q;
         assign up_op   = stg_g[s-1].cnt_g.op_q;
         assign up_tag  = stg_g[s-1].tag_q;
      end

      // Count is kept right-aligned: bit j of up_cnt drives this stage's j-th level.
      for (genvar j = 0; j < NL; j++) begin : lvl_g
         logic [WIDTH-1:0] lin;
         logic [WIDTH-1:0] lout;
         if (j == 0) begin : first_g
            assign lin = up_data;
         end else begin : chain_g
            assign lin = lvl_g[j-1].lout;
         end
         shift_level #(.WIDTH(WIDTH), .DIST(1 << (BASE + j))) u_level (
            .data_i (lin),
            .en_i   (up_cnt[j]),
            .op_i   (up_op),
            .data_o (lout)
         );
      end

      assign data_d = lvl_g[NL-1].lout;
      assign v[s]   = v_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q    <= 1'b0;
            data_q <= '0;
            tag_q  <= '0;
         end else if (rdy[s]) begin
            v_q <= up_v;
            if (up_v) begin
               data_q <= data_d;
               tag_q  <= up_tag;
            end
         end
      end

      if (s < NSTG - 1) begin : cnt_g
         logic [CNT_W-1:0] cnt_q;
         logic [1:0]       op_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_q <= '0;
               op_q  <= OP_ROL;
            end else if (rdy[s] && up_v) begin
               cnt_q <= up_cnt >> NL;
               op_q  <= up_op;
            end
         end
      end
   end

   assign in_ready  = rdy[0];
   assign out_valid = stg_g[NSTG-1].v_q;
   assign out_data  = stg_g[NSTG-1].data_q;
   assign out_tag   = stg_g[NSTG-1].tag_q;

endmodule

// File: tb/tb_pipe_shifter.sv
// Directed bench for pipe_shifter: default 16-bit/4-stage instance plus a 32-bit/3-stage instance.
module tb_pipe_shifter;
   import shifter_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [15:0] a_in_data, a_out_data;
   logic [3:0]  a_in_cnt, a_in_tag, a_out_tag;
   logic [1:0]  a_in_op;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [31:0] b_in_data, b_out_data;
   logic [4:0]  b_in_cnt;
   logic [3:0]  b_in_tag, b_out_tag;
   logic [1:0]  b_in_op;

   int pass_cnt = 0;
   int total    = 0;

   pipe_shifter u_dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .in_cnt(a_in_cnt), .in_op(a_in_op), .in_tag(a_in_tag),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_data(a_out_data), .out_tag(a_out_tag)
   );

   pipe_shifter #(.WIDTH(32), .REG_EVERY(2)) u_dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .in_cnt(b_in_cnt), .in_op(b_in_op), .in_tag(b_in_tag),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_data(b_out_data), .out_tag(b_out_tag)
   );

   function automatic logic [31:0] ref32(input logic [31:0] d, input int n, input logic [1:0] op);
      case (op)
         OP_ROL:  return (d << n) | (d >> (32 - n));
         OP_SLL:  return d << n;
         OP_ROR:  return (d >> n) | (d << (32 - n));
         default: return $signed(d) >>> n;
      endcase
   endfunction

   // Issue one op to instance A and wait for its result; latency counts the accept edge as 1.
   task automatic run_a(input logic [15:0] d, input logic [3:0] c, input logic [1:0] op,
                        input logic [3:0] tag, output logic [15:0] od, output logic [3:0] ot,
                        output int lat);
      @(negedge clk);
      a_in_valid = 1'b1; a_in_data = d; a_in_cnt = c; a_in_op = op; a_in_tag = tag;
      a_out_ready = 1'b1;
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      lat = 1;
      while (!a_out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      od = a_out_data; ot = a_out_tag;
      @(posedge clk); #1;
   endtask

   task automatic run_b(input logic [31:0] d, input logic [4:0] c, input logic [1:0] op,
                        input logic [3:0] tag, output logic [31:0] od, output logic [3:0] ot,
                        output int lat);
      @(negedge clk);
      b_in_valid = 1'b1; b_in_data = d; b_in_cnt = c; b_in_op = op; b_in_tag = tag;
      b_out_ready = 1'b1;
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      lat = 1;
      while (!b_out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      od = b_out_data; ot = b_out_tag;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      a_in_valid = 1'b0; a_in_data = '0; a_in_cnt = '0; a_in_op = OP_ROL; a_in_tag = '0;
      a_out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_data = '0; b_in_cnt = '0; b_in_op = OP_ROL; b_in_tag = '0;
      b_out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", a_out_valid); else pass_cnt++;
      total++; if (a_out_data !== 16'h0) $display("FAIL reset_out_data: got %h want 0000", a_out_data); else pass_cnt++;
      total++; if (a_out_tag !== 4'h0) $display("FAIL reset_out_tag: got %h want 0", a_out_tag); else pass_cnt++;
      total++; if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", a_in_ready); else pass_cnt++;
      total++; if (b_out_valid !== 1'b0) $display("FAIL reset_b_out_valid: got %b want 0", b_out_valid); else pass_cnt++;
   endtask

   task automatic test_basic;
      logic [15:0] od; logic [3:0] ot; int lat;
      run_a(16'h8001, 4'd1, OP_ROL, 4'd1, od, ot, lat);
      total++; if (od !== 16'h0003) $display("FAIL rol_data: got %h want 0003", od); else pass_cnt++;
      total++; if (ot !== 4'd1) $display("FAIL rol_tag: got %h want 1", ot); else pass_cnt++;
      total++; if (lat !== 4) $display("FAIL rol_latency: got %0d want 4", lat); else pass_cnt++;
      run_a(16'h0001, 4'd4, OP_ROR, 4'd2, od, ot, lat);
      total++; if (od !== 16'h1000) $display("FAIL ror_data: got %h want 1000", od); else pass_cnt++;
      total++; if (ot !== 4'd2) $display("FAIL ror_tag: got %h want 2", ot); else pass_cnt++;
      total++; if (lat !== 4) $display("FAIL ror_latency: got %0d want 4", lat); else pass_cnt++;
   endtask

   task automatic test_edges;
      logic [15:0] od; logic [3:0] ot; int lat;
      run_a(16'hFFFF, 4'd15, OP_SLL, 4'd3, od, ot, lat);
      total++; if (od !== 16'h8000) $display("FAIL sll15: got %h want 8000", od); else pass_cnt++;
      run_a(16'h8000, 4'd15, OP_SRA, 4'd4, od, ot, lat);
      total++; if (od !== 16'hFFFF) $display("FAIL sra15: got %h want ffff", od); else pass_cnt++;
      run_a(16'h4000, 4'd14, OP_SRA, 4'd5, od, ot, lat);
      total++; if (od !== 16'h0001) $display("FAIL sra14: got %h want 0001", od); else pass_cnt++;
      run_a(16'h8421, 4'd15, OP_ROL, 4'd6, od, ot, lat);
      total++; if (od !== 16'hC210) $display("FAIL rol15: got %h want c210", od); else pass_cnt++;
   endtask

   task automatic test_count_zero;
      logic [15:0] od; logic [3:0] ot; int lat;
      for (int op = 0; op < 4; op++) begin
         run_a(16'hA5C3, 4'd0, op[1:0], 4'(8 + op), od, ot, lat);
         total++; if (od !== 16'hA5C3) $display("FAIL cnt0_data_op%0d: got %h want a5c3", op, od); else pass_cnt++;
         total++; if (ot !== 4'(8 + op)) $display("FAIL cnt0_tag_op%0d: got %h want %h", op, ot, 4'(8 + op)); else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back;
      int acc = 0, got = 0, blk_acc = -1, extra = 0;
      logic saw_drop = 1'b0;
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
         @(negedge clk);
         a_out_ready = !(cyc >= 3 && cyc <= 9);
         a_in_valid  = (acc < 8);
         a_in_data   = 16'h0001; a_in_cnt = acc[3:0]; a_in_op = OP_ROL; a_in_tag = acc[3:0];
         #1;
         if (a_in_valid && !a_in_ready && !saw_drop) begin
            saw_drop = 1'b1;
            blk_acc  = acc;
         end
         if (a_out_valid && a_out_ready) begin
            total++; if (a_out_tag !== got[3:0]) $display("FAIL b2b_tag%0d: got %h want %h", got, a_out_tag, got[3:0]); else pass_cnt++;
            total++; if (a_out_data !== (16'h0001 << got)) $display("FAIL b2b_data%0d: got %h want %h", got, a_out_data, 16'h0001 << got); else pass_cnt++;
            got++;
         end
         if (a_in_valid && a_in_ready) acc++;
      end
      @(negedge clk);
      a_in_valid = 1'b0; a_out_ready = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
         if (a_out_valid) extra++;
      end
      total++; if (got !== 8) $display("FAIL b2b_count: got %0d want 8", got); else pass_cnt++;
      total++; if (saw_drop !== 1'b1) $display("FAIL b2b_ready_drop: got %b want 1", saw_drop); else pass_cnt++;
      total++; if (blk_acc !== 4) $display("FAIL b2b_inflight_at_drop: got %0d want 4", blk_acc); else pass_cnt++;
      total++; if (extra !== 0) $display("FAIL b2b_duplicates: got %0d want 0", extra); else pass_cnt++;
   endtask

   task automatic test_reset_inflight;
      logic [15:0] od; logic [3:0] ot; int lat; int stale = 0;
      @(negedge clk);
      a_out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a_in_valid = 1'b1; a_in_data = 16'h00F0; a_in_cnt = 4'd0; a_in_op = OP_ROL; a_in_tag = i[3:0];
         @(posedge clk); #1;
      end
      a_in_valid = 1'b0;
      @(posedge clk); #1;
      total++; if (a_out_valid !== 1'b1) $display("FAIL inflight_head: got %b want 1", a_out_valid); else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      total++; if (a_out_valid !== 1'b0) $display("FAIL async_reset_out_valid: got %b want 0", a_out_valid); else pass_cnt++;
      total++; if (a_out_data !== 16'h0) $display("FAIL async_reset_out_data: got %h want 0000", a_out_data); else pass_cnt++;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1; a_out_ready = 1'b1;
      #1;
      total++; if (a_in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b want 1", a_in_ready); else pass_cnt++;
      repeat (8) begin
         @(posedge clk); #1;
         if (a_out_valid) stale++;
      end
      total++; if (stale !== 0) $display("FAIL stale_results: got %0d want 0", stale); else pass_cnt++;
      run_a(16'h0F00, 4'd4, OP_SLL, 4'd9, od, ot, lat);
      total++; if (od !== 16'hF000) $display("FAIL post_reset_data: got %h want f000", od); else pass_cnt++;
      total++; if (lat !== 4) $display("FAIL post_reset_latency: got %0d want 4", lat); else pass_cnt++;
   endtask

   task automatic test_wide;
      logic [31:0] od, d, expv; logic [3:0] ot; int lat; int n; logic [1:0] op;
      run_b(32'h8000_0000, 5'd31, OP_ROL, 4'd3, od, ot, lat);
      total++; if (od !== 32'h4000_0000) $display("FAIL wide_rol31: got %h want 40000000", od); else pass_cnt++;
      total++; if (lat !== 3) $display("FAIL wide_latency: got %0d want 3", lat); else pass_cnt++;
      total++; if (ot !== 4'd3) $display("FAIL wide_tag: got %h want 3", ot); else pass_cnt++;
      run_b(32'h8000_0000, 5'd31, OP_SRA, 4'd4, od, ot, lat);
      total++; if (od !== 32'hFFFF_FFFF) $display("FAIL wide_sra31: got %h want ffffffff", od); else pass_cnt++;
      for (int i = 0; i < 16; i++) begin
         d  = $urandom;
         n  = $urandom_range(0, 31);
         op = 2'($urandom_range(0, 3));
         expv = ref32(d, n, op);
         run_b(d, 5'(n), op, i[3:0], od, ot, lat);
         total++; if (od !== expv) $display("FAIL wide_rand%0d op%0d cnt%0d: got %h want %h", i, op, n, od, expv); else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_edges();
      test_count_zero();
      test_back_to_back();
      test_reset_inflight();
      test_wide();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
